dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: max consecutive cycles port 1 waits under CPU priority.
REQ-002 Parameter AW, default 8: data-memory address width.
REQ-003 Parameter DW, default 16: data-memory word width.
REQ-004 Clk  input  1  single clock; all state updates on rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 cpu_prio  input  1  1 = port 0 (CPU) fixed priority with starvation guard; 0 = round-robin.
REQ-007 req0, req1  input  1 each  access request; held high until the matching grant.
REQ-008 wr0, wr1  input  1 each  1 = write, 0 = read; valid while req is high.
REQ-009 addr0, addr1  input  AW each  word address.
REQ-010 wdata0, wdata1  input  DW each  write data.
REQ-011 gnt0, gnt1  output  1 each  combinational grant; the access is issued in this cycle.
REQ-012 rvalid0, rvalid1  output  1 each  registered read-data-valid pulse.
REQ-013 rdata0, rdata1  output  DW each  mem_rdata routed to both ports; meaningful only while the matching rvalid is high.
REQ-014 mem_addr  output  AW  memory address.
REQ-015 mem_wr  output  1  memory write enable.
REQ-016 mem_wdata  output  DW  memory write data.
REQ-017 mem_rdata  input  DW  synchronous RAM output; valid one cycle after a read is issued.

Function
REQ-018 The block shall assert at most one of gnt0/gnt1 per cycle, and only to a port whose req is high.
REQ-019 In a granted cycle, mem_addr/mem_wr/mem_wdata shall equal the granted port's addr/wr/wdata in that same cycle (zero-latency issue).
REQ-020 In a cycle with no grant, mem_wr shall be 0, mem_addr 0 and mem_wdata 0.
REQ-021 A granted read shall produce rvalid on the granted port exactly one cycle later, with rdata equal to mem_rdata in that cycle; a granted write shall produce no rvalid.
REQ-022 Accesses shall be fully pipelined: a new grant may issue in the same cycle that rvalid returns for the previous read, giving one access per cycle sustained.
REQ-023 With a single requester, that port shall be granted in the same cycle, in either mode.
REQ-024 Round-robin mode (cpu_prio=0), both requesting: grant the port not granted most recently; the last-granted pointer updates only on a grant.
REQ-025 Priority mode (cpu_prio=1), both requesting: grant port 0 unless starve_cnt == STARVE_LIMIT, in which case grant port 1.
REQ-026 starve_cnt (width clog2(STARVE_LIMIT+1)) increments each cycle req1=1 and gnt1=0, saturates at STARVE_LIMIT, and clears on gnt1 or req1=0.
REQ-027 starve_cnt shall keep counting in round-robin mode but have no effect there; a mode change takes effect in the same cycle.
REQ-028 Arbitration decisions shall not depend on the outstanding-read state; only the request signals, the pointer, starve_cnt and cpu_prio drive them.

Reset
REQ-029 Reset=1 at a clock edge shall clear rvalid0/rvalid1, starve_cnt and the pending-read tracking, and set the last-granted pointer to port 1 so port 0 wins the first round-robin tie.
REQ-030 While Reset=1, gnt0, gnt1 and mem_wr shall be 0, and mem_addr and mem_wdata shall be 0.
REQ-031 A read granted in the cycle before Reset asserts shall produce no rvalid after the reset edge.

Structure
REQ-032 Shared package arb_pkg shall hold the port-id typedef (PORT_CPU=0, PORT_EXT=1) and the STARVE_LIMIT default constant.
REQ-033 The starvation counter shall be a sub-module named starve_counter (inputs: waiting, granted; output: limit_hit); the arbiter logic, pointer and read-return pipe stay in dmem_arbiter.

Verification
REQ-034 Round-robin: cpu_prio=0, req0=req1=1 (reads, addr0=8'h10, addr1=8'h20) for 4 cycles after reset -> grant order 0,1,0,1; mem_addr 10,20,10,20; rvalid pulses one cycle behind each grant on the matching port.
REQ-035 Starvation: cpu_prio=1, both requesting continuously -> gnt0 for 4 cycles, gnt1 in the 5th, then gnt0 again and starve_cnt back to 0.
REQ-036 Write/read: port 0 writes 16'hBEEF to 8'hBC, next cycle port 1 reads 8'hBC -> mem_wr=1 in the first cycle only; rvalid1=1 with rdata1=16'hBEEF the following cycle; rvalid0 stays 0.
REQ-037 Back-to-back: port 1 alone issues reads to 8'h01..8'h04 in consecutive cycles -> gnt1 high 4 cycles; rvalid1 high 4 consecutive cycles, each one cycle after its grant.
REQ-038 Reset mid-op: read granted in cycle N, Reset=1 in cycle N+1 -> rvalid0=rvalid1=0 in cycle N+1; after release with both requesting, port 0 is granted first.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the data-memory arbiter: port identifiers and
// default parameter values used by the arbiter, its interface and sub-blocks.
package arb_pkg;

   // Port identifiers; the last-granted pointer is stored in this type.
   typedef enum logic {
      PORT_CPU = 1'b0,
      PORT_EXT = 1'b1
   } port_id_t;

   // Default number of consecutive cycles port 1 may wait under CPU priority.
   localparam int STARVE_LIMIT_DEFAULT = 4;

   // Default data-memory geometry.
   localparam int AW_DEFAULT = 8;
   localparam int DW_DEFAULT = 16;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between two requesting ports, the arbiter and a synchronous RAM.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface dmem_arbiter_if
   import arb_pkg::*;
#(
   parameter int AW = AW_DEFAULT,
   parameter int DW = DW_DEFAULT
);
   logic          cpu_prio;
   logic          req0;
   logic          req1;
   logic          wr0;
   logic          wr1;
   logic [AW-1:0] addr0;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wdata0;
   logic [DW-1:0] wdata1;
   logic          gnt0;
   logic          gnt1;
   logic          rvalid0;
   logic          rvalid1;
   logic [DW-1:0] rdata0;
   logic [DW-1:0] rdata1;
   logic [AW-1:0] mem_addr;
   logic          mem_wr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  cpu_prio, req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, mem_rdata,
      output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_addr, mem_wr, mem_wdata
   );

   modport master (
      output cpu_prio, req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, mem_rdata,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_addr, mem_wr, mem_wdata
   );

endinterface

// File: rtl/dmem_arbiter_starve_counter.sv
// Counts consecutive cycles that port 1 waits without a grant, saturating at
// LIMIT. limit_hit tells the arbiter to hand port 1 the next priority tie.
module starve_counter
   import arb_pkg::*;
#(
   parameter int LIMIT = STARVE_LIMIT_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic waiting,
   input  logic granted,
   output logic limit_hit
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt_reg;
   logic [CW-1:0] cnt_next;

   // Clear when port 1 is served or stops asking; otherwise count up to LIMIT.
   always_comb begin
      cnt_next = cnt_reg;
      if (!waiting || granted) begin
         cnt_next = '0;
      end else if (cnt_reg != CW'(LIMIT)) begin
         cnt_next = cnt_reg + CW'(1);
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   assign limit_hit = (cnt_reg == CW'(LIMIT));

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single synchronous data memory. Grants are
// combinational and the access issues in the grant cycle; read data returns
// one cycle later with a registered rvalid on the port that asked for it.
module dmem_arbiter
   import arb_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
   parameter int AW           = AW_DEFAULT,
   parameter int DW           = DW_DEFAULT
) (
   input  logic           clk,
   input  logic           reset,
   dmem_arbiter_if.slave  bus
);

   port_id_t      last_reg;
   logic          rvalid0_reg;
   logic          rvalid1_reg;
   logic          limit_hit;
   logic          gnt0;
   logic          gnt1;
   logic [AW-1:0] mem_addr_next;
   logic          mem_wr_next;
   logic [DW-1:0] mem_wdata_next;

   starve_counter #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk       (clk),
      .reset     (reset),
      .waiting   (bus.req1),
      .granted   (gnt1),
      .limit_hit (limit_hit)
   );

   // Grant decision: a lone requester always wins; ties go by mode.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!reset) begin
         if (bus.req0 && bus.req1) begin
            if (bus.cpu_prio) begin
               gnt0 = !limit_hit;
               gnt1 = limit_hit;
            end else begin
               gnt0 = (last_reg == PORT_EXT);
               gnt1 = (last_reg == PORT_CPU);
            end
         end else begin
            gnt0 = bus.req0;
            gnt1 = bus.req1;
         end
      end
   end

   // Route the granted port onto the memory bus; idle bus is all zeros.
   always_comb begin
      mem_addr_next  = '0;
      mem_wr_next    = 1'b0;
      mem_wdata_next = '0;
      if (gnt0) begin
         mem_addr_next  = bus.addr0;
         mem_wr_next    = bus.wr0;
         mem_wdata_next = bus.wdata0;
      end else if (gnt1) begin
         mem_addr_next  = bus.addr1;
         mem_wr_next    = bus.wr1;
         mem_wdata_next = bus.wdata1;
      end
   end

   // Last-granted pointer and one-deep read-return pipe per port.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_reg    <= PORT_EXT;
         rvalid0_reg <= 1'b0;
         rvalid1_reg <= 1'b0;
      end else begin
         if (gnt0) begin
            last_reg <= PORT_CPU;
         end else if (gnt1) begin
            last_reg <= PORT_EXT;
         end
         rvalid0_reg <= gnt0 && !bus.wr0;
         rvalid1_reg <= gnt1 && !bus.wr1;
      end
   end

   assign bus.gnt0      = gnt0;
   assign bus.gnt1      = gnt1;
   assign bus.mem_addr  = mem_addr_next;
   assign bus.mem_wr    = mem_wr_next;
   assign bus.mem_wdata = mem_wdata_next;

   // A read in flight when reset rises must not surface during reset.
   assign bus.rvalid0   = rvalid0_reg && !reset;
   assign bus.rvalid1   = rvalid1_reg && !reset;
   assign bus.rdata0    = bus.mem_rdata;
   assign bus.rdata1    = bus.mem_rdata;

endmodule
